// File: rtl/game_flow_ctrl.sv
// Typing-game flow sequencer: SELECT -> COUNTDOWN -> INGAME -> FINISH, driven by a 100 Hz enable.
// Optional FINISH auto-return to SELECT is enabled by defining GAME_FLOW_AUTO_RETURN_EN.
module game_flow_ctrl #(
  parameter int TICKS_PER_SEC   = 100,
  parameter int CD_SECONDS      = 3,
  parameter int T_MIN           = 15,
  parameter int T_MAX           = 60,
  parameter int T_STEP          = 15,
  parameter int W_MIN           = 10,
  parameter int W_MAX           = 50,
`ifdef GAME_FLOW_AUTO_RETURN_EN
  parameter int W_STEP          = 10,
  parameter int AUTO_RETURN_SEC = 10
`else
  parameter int W_STEP          = 10
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100hz,
  input  logic       btn_start,
  input  logic       btn_abort,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       finish,
  output logic [1:0] state,
  output logic       mode,
  output logic [6:0] value,
  output logic [1:0] cd_digit,
  output logic       game_start,
  output logic [7:0] elapsed_sec,
  output logic       round_done
);

  localparam logic [1:0] S_SELECT    = 2'd0;
  localparam logic [1:0] S_COUNTDOWN = 2'd1;
  localparam logic [1:0] S_INGAME    = 2'd2;
  localparam logic [1:0] S_FINISH    = 2'd3;

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  localparam logic [6:0] T_MIN_V  = 7'(T_MIN);
  localparam logic [6:0] T_MAX_V  = 7'(T_MAX);
  localparam logic [6:0] T_STEP_V = 7'(T_STEP);
  localparam logic [6:0] W_MIN_V  = 7'(W_MIN);
  localparam logic [6:0] W_MAX_V  = 7'(W_MAX);
  localparam logic [6:0] W_STEP_V = 7'(W_STEP);
  localparam logic [1:0] CD_INIT  = 2'(CD_SECONDS);

`ifdef GAME_FLOW_AUTO_RETURN_EN
  localparam int DWELL_W = $clog2(AUTO_RETURN_SEC + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_RETURN_SEC - 1);
`endif

  // Saturating helpers: the 8-bit intermediate keeps the 7-bit bounds from wrapping.
  function automatic logic [6:0] sat_step_up(input logic [6:0] v, input logic [6:0] step,
                                             input logic [6:0] max);
    logic [7:0] sum;
    sum = {1'b0, v} + {1'b0, step};
    return (sum > {1'b0, max}) ? max : sum[6:0];
  endfunction

  function automatic logic [6:0] sat_step_down(input logic [6:0] v, input logic [6:0] step,
                                               input logic [6:0] min);
    logic [7:0] floor_plus;
    floor_plus = {1'b0, min} + {1'b0, step};
    return ({1'b0, v} < floor_plus) ? min : (v - step);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_cnt_nxt;
  logic [1:0]        state_nxt;
  logic              mode_nxt;
  logic [6:0]        value_nxt;
  logic [1:0]        cd_digit_nxt;
  logic [7:0]        elapsed_nxt;
  logic              game_start_nxt;
  logic              round_done_nxt;
`ifdef GAME_FLOW_AUTO_RETURN_EN
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_cnt_nxt;
`endif

  logic [6:0] cur_min;
  logic [6:0] cur_max;
  logic [6:0] cur_step;
  logic [6:0] other_min;
  logic       sec_roll;

  always_comb begin
    cur_min   = mode ? W_MIN_V  : T_MIN_V;
    cur_max   = mode ? W_MAX_V  : T_MAX_V;
    cur_step  = mode ? W_STEP_V : T_STEP_V;
    other_min = mode ? T_MIN_V  : W_MIN_V;
  end

  assign sec_roll = tick_100hz && (tick_cnt == TICK_LAST);

  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode;
    value_nxt      = value;
    cd_digit_nxt   = cd_digit;
    tick_cnt_nxt   = tick_cnt;
    elapsed_nxt    = elapsed_sec;
    game_start_nxt = 1'b0;
    round_done_nxt = 1'b0;
`ifdef GAME_FLOW_AUTO_RETURN_EN
    dwell_cnt_nxt  = dwell_cnt;
`endif

    if (btn_abort && (state != S_SELECT)) begin
      state_nxt    = S_SELECT;
      cd_digit_nxt = 2'd0;
      tick_cnt_nxt = '0;
      elapsed_nxt  = 8'd0;
    end else begin
      case (state)
        S_SELECT: begin
          // Abort in SELECT does nothing but still masks the lower-priority buttons.
          if (btn_abort) begin
            state_nxt = S_SELECT;
          end else if (btn_start) begin
            state_nxt    = S_COUNTDOWN;
            cd_digit_nxt = CD_INIT;
            tick_cnt_nxt = '0;
            elapsed_nxt  = 8'd0;
          end else if (btn_mode) begin
            mode_nxt  = ~mode;
            value_nxt = other_min;
          end else if (btn_up) begin
            value_nxt = sat_step_up(value, cur_step, cur_max);
          end else if (btn_down) begin
            value_nxt = sat_step_down(value, cur_step, cur_min);
          end
        end

        S_COUNTDOWN: begin
          if (sec_roll) begin
            tick_cnt_nxt = '0;
            cd_digit_nxt = cd_digit - 2'd1;
            if (cd_digit == 2'd1) begin
              state_nxt      = S_INGAME;
              game_start_nxt = 1'b1;
            end
          end else if (tick_100hz) begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end

        S_INGAME: begin
          // finish wins over a coinciding second rollover, so that increment is lost.
          if (finish) begin
            state_nxt      = S_FINISH;
            round_done_nxt = 1'b1;
            tick_cnt_nxt   = '0;
`ifdef GAME_FLOW_AUTO_RETURN_EN
            dwell_cnt_nxt  = '0;
`endif
          end else if (sec_roll) begin
            tick_cnt_nxt = '0;
            elapsed_nxt  = sat_inc8(elapsed_sec);
          end else if (tick_100hz) begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end

        S_FINISH: begin
          if (btn_start) begin
            state_nxt    = S_SELECT;
            tick_cnt_nxt = '0;
          end
`ifdef GAME_FLOW_AUTO_RETURN_EN
          else if (sec_roll) begin
            tick_cnt_nxt = '0;
            if (dwell_cnt == DWELL_LAST) begin
              state_nxt     = S_SELECT;
              dwell_cnt_nxt = '0;
            end else begin
              dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
            end
          end else if (tick_100hz) begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
`endif
        end

        default: state_nxt = S_SELECT;
      endcase
    end
  end

  // Register stage: every output is a flop, updated from the next-state logic above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_SELECT;
      mode        <= 1'b0;
      value       <= T_MIN_V;
      cd_digit    <= 2'd0;
      tick_cnt    <= '0;
      elapsed_sec <= 8'd0;
      game_start  <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      mode        <= mode_nxt;
      value       <= value_nxt;
      cd_digit    <= cd_digit_nxt;
      tick_cnt    <= tick_cnt_nxt;
      elapsed_sec <= elapsed_nxt;
      game_start  <= game_start_nxt;
      round_done  <= round_done_nxt;
    end
  end

`ifdef GAME_FLOW_AUTO_RETURN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt_nxt;
    end
  end
`endif

endmodule
